// File: rtl/serial_addsub_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_addsub_if
// ----------------------------------------------------------------------------
// Operand/result bundle for the digit-serial adder/subtractor.
//   in_valid/in_ready : operand handshake (a, b, sub travel with it)
//   out_valid/out_ready : result handshake (sum, carry_out, overflow)
//   busy : block is working on or holding a result
// master modport = operand producer / result consumer, slave = the adder.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// serial_addsub
// ----------------------------------------------------------------------------
// Multi-cycle two's-complement adder/subtractor. Operands are consumed DIGIT
// bits per clock through a DIGIT-bit ripple slice with a registered carry,
// so a WIDTH-bit result takes NDIG = WIDTH/DIGIT slice cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if.slave (operand/result handshakes, flags, busy)
// Parameters: WIDTH (multiple of DIGIT, >= 4), DIGIT (divides WIDTH).
// Revision: 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_addsub_if.slave   bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] acc;       // slice results collect here, LSB slice first
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_reg;   // presented result, only updated on completion
  logic             carry;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_slice;
  logic [DIGIT:0]   slice;
  logic             msb_cin;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_slice = (state == RUN) && (cnt == CW'(NDIG - 1));

  // One DIGIT-bit ripple slice; bit DIGIT is the slice carry out.
  assign slice = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry};

  // Carry into the slice MSB, recovered from its sum bit. On the last slice
  // this is the carry into bit WIDTH-1, needed for signed overflow.
  assign msb_cin = slice[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];

  generate
    if (NDIG == 1) begin : g_single_slice
      assign acc_nxt = slice[DIGIT-1:0];
    end else begin : g_multi_slice
      assign acc_nxt = {slice[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last_slice)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      sum_reg       <= '0;
      carry         <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      cnt           <= '0;
    end else if (accept) begin
      // Subtraction as A + ~B + 1: invert B here, inject the +1 as carry-in.
      a_reg <= bus.a;
      b_reg <= bus.b ^ {WIDTH{bus.sub}};
      carry <= bus.sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      carry <= slice[DIGIT];
      cnt   <= cnt + CW'(1);
      acc   <= acc_nxt;
      if (last_slice) begin
        sum_reg       <= acc_nxt;
        carry_out_reg <= slice[DIGIT];
        overflow_reg  <= msb_cin ^ slice[DIGIT];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;

endmodule
`default_nettype wire
